// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, WIDTH iterations.
// Start/busy/done handshake; results and flags are presented through a registered output stage.
module seq_divider8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // r_dividend shifts out dividend bits at the top and collects quotient bits at the bottom
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_prem;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] r_res_q;
  logic [WIDTH-1:0] r_res_r;
  logic             r_res_dbz;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_prem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic             w_busy;
  logic             w_done;

  assign w_accept = start && (r_state != StCalc);
  assign w_last   = (r_count == LastCnt);

  // The partial remainder stays below the divisor, so a 9-bit trial has an unambiguous sign bit
  assign w_shift     = {r_prem, r_dividend[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_divisor};
  assign w_qbit      = ~w_trial[WIDTH];
  assign w_prem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_next = {r_dividend[WIDTH-2:0], w_qbit};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_next = (B == '0) ? StDone : StCalc;
        end else begin
          w_state_next = StIdle;
        end
      end
      StCalc: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State-decoded outputs, registered below
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      StCalc:  w_busy = 1'b1;
      StDone:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Iteration datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_prem     <= '0;
      r_count    <= '0;
      r_res_q    <= '0;
      r_res_r    <= '0;
      r_res_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_dividend <= A;
      r_divisor  <= B;
      r_prem     <= '0;
      r_count    <= '0;
      if (B == '0) begin
        r_res_q   <= '1;
        r_res_r   <= A;
        r_res_dbz <= 1'b1;
      end else begin
        r_res_dbz <= 1'b0;
      end
    end else if (r_state == StCalc) begin
      r_prem     <= w_prem_next;
      r_dividend <= w_quot_next;
      r_count    <= r_count + CntW'(1);
      if (w_last) begin
        r_res_q <= w_quot_next;
        r_res_r <= w_prem_next;
      end
    end
  end

  // Output stage: results become visible together with the done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_r    <= '0;
      r_dbz  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy;
      r_done <= w_done;
      if (w_done) begin
        r_q   <= r_res_q;
        r_r   <= r_res_r;
        r_dbz <= r_res_dbz;
      end else if (w_accept) begin
        r_dbz <= 1'b0;
      end
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
